nco_sincos: RTL

Numerically controlled oscillator that produces the signed sine/cosine pair consumed by the carrier-offset rotation stage, which feeds `i_dataSin`/`i_dataCos`. A phase accumulator is advanced by a signed frequency control word and offset by a static phase. The phase is then truncated to a LUT index and mapped through a folded quarter-wave table to S(NB_OUTPUT,NBF_OUTPUT) samples. The design is a three-register pipeline with an input enable and an output valid.

---
 rtl/nco_pkg.sv | 24 ++
 rtl/nco_quarter_lut.sv | 42 ++++
 rtl/nco_sincos.sv | 127 ++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared constants, quadrant encodings and the quarter-wave table generator
// for the nco_sincos oscillator.
package nco_pkg;

    localparam int NB_PHASE_DEF    = 16;
    localparam int NB_LUT_ADDR_DEF = 8;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    // T[k] = round((2^nbf - 1) * sin(pi/2 * (k + 0.5) / m)); evaluated at elaboration only.
    function automatic int quarter_sin(input int k, input int m, input int nbf);
        real amp;
        real ang;
        amp = real'((1 << nbf) - 1);
        ang = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(m);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// Dual-read registered quarter-wave magnitude ROM; forms pipeline stage 2
// of nco_sincos (one read port for sine, one for cosine).
module nco_quarter_lut
    import nco_pkg::*;
#(
    parameter int NB_ADDR = 6,
    parameter int NB_MAG  = 7,
    parameter int NBF     = 7
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [NB_ADDR-1:0] i_addr_sin,
    input  logic [NB_ADDR-1:0] i_addr_cos,
    output logic [NB_MAG-1:0]  o_mag_sin,
    output logic [NB_MAG-1:0]  o_mag_cos
);

    localparam int M = 1 << NB_ADDR;

    logic [NB_MAG-1:0] rom [M];
    logic [NB_MAG-1:0] mag_sin_q;
    logic [NB_MAG-1:0] mag_cos_q;

    for (genvar k = 0; k < M; k++) begin : g_rom
        localparam int TV = quarter_sin(k, M, NBF);
        assign rom[k] = TV[NB_MAG-1:0];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mag_sin_q <= '0;
            mag_cos_q <= '0;
        end else begin
            mag_sin_q <= rom[i_addr_sin];
            mag_cos_q <= rom[i_addr_cos];
        end
    end

    assign o_mag_sin = mag_sin_q;
    assign o_mag_cos = mag_cos_q;

endmodule

// File: rtl/nco_sincos.sv
// Three-stage sine/cosine NCO: phase accumulator, folded quarter-wave lookup,
// signed outputs. Define NCO_DITHER_EN to add LFSR phase dither before truncation.
module nco_sincos
    import nco_pkg::*;
#(
    parameter int NB_PHASE    = NB_PHASE_DEF,
    parameter int NB_LUT_ADDR = NB_LUT_ADDR_DEF,
    parameter int NB_OUTPUT   = 8,
    parameter int NBF_OUTPUT  = 7
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_sync_clear,
    input  logic [NB_PHASE-1:0]         i_freq_word,
    input  logic [NB_PHASE-1:0]         i_phase_offset,
    output logic signed [NB_OUTPUT-1:0] o_dataSin,
    output logic signed [NB_OUTPUT-1:0] o_dataCos,
    output logic                        o_valid
);

    localparam int NB_K   = NB_LUT_ADDR - 2;
    localparam int NB_MAG = NB_OUTPUT - 1;

    logic [NB_PHASE-1:0]    acc_q, acc_d;
    logic [NB_PHASE-1:0]    acc_base;
    logic [NB_PHASE-1:0]    phase_sum;
    logic [NB_PHASE-1:0]    dither;
    logic [NB_LUT_ADDR-1:0] p_q, p_d;
    logic [2:0]             vld_q;
    logic                   neg_sin_q, neg_cos_q;
    logic signed [NB_OUTPUT-1:0] sin_q, sin_d, cos_q, cos_d;

    quad_e             q_sin, q_cos;
    logic [NB_K-1:0]   k_idx, addr_sin, addr_cos;
    logic              neg_sin, neg_cos;
    logic [NB_MAG-1:0] mag_sin, mag_cos;

`ifdef NCO_DITHER_EN
    localparam int NB_DITH = NB_PHASE - NB_LUT_ADDR;

    logic [14:0] lfsr_q, lfsr_d;

    // Fibonacci x^15 + x^14 + 1, stepped once per launched sample.
    always_comb begin
        lfsr_d = lfsr_q;
        if (i_enable) lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) lfsr_q <= 15'h0001;
        else         lfsr_q <= lfsr_d;
    end

    assign dither = NB_PHASE'(lfsr_q[NB_DITH-1:0]);
`else
    assign dither = '0;
`endif

    // Clear zeroes the base the current sample and the next accumulation use.
    always_comb begin
        acc_base  = i_sync_clear ? '0 : acc_q;
        phase_sum = acc_base + i_phase_offset + dither;
        p_d       = NB_LUT_ADDR'(phase_sum >> (NB_PHASE - NB_LUT_ADDR));
        acc_d     = acc_q;
        if (i_enable)          acc_d = acc_base + i_freq_word;
        else if (i_sync_clear) acc_d = '0;
    end

    // Fold: odd quadrants read the table mirrored, upper half-turn negates.
    always_comb begin
        q_sin    = quad_e'(p_q[NB_LUT_ADDR-1 -: 2]);
        q_cos    = quad_e'(p_q[NB_LUT_ADDR-1 -: 2] + 2'd1);
        k_idx    = p_q[NB_K-1:0];
        addr_sin = (q_sin == QUAD_1 || q_sin == QUAD_3) ? ~k_idx : k_idx;
        addr_cos = (q_cos == QUAD_1 || q_cos == QUAD_3) ? ~k_idx : k_idx;
        neg_sin  = (q_sin == QUAD_2 || q_sin == QUAD_3);
        neg_cos  = (q_cos == QUAD_2 || q_cos == QUAD_3);
    end

    nco_quarter_lut #(
        .NB_ADDR (NB_K),
        .NB_MAG  (NB_MAG),
        .NBF     (NBF_OUTPUT)
    ) u_lut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_addr_sin (addr_sin),
        .i_addr_cos (addr_cos),
        .o_mag_sin  (mag_sin),
        .o_mag_cos  (mag_cos)
    );

    always_comb begin
        sin_d = sin_q;
        cos_d = cos_q;
        if (vld_q[1]) begin
            sin_d = neg_sin_q ? -$signed({1'b0, mag_sin}) : $signed({1'b0, mag_sin});
            cos_d = neg_cos_q ? -$signed({1'b0, mag_cos}) : $signed({1'b0, mag_cos});
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_q     <= '0;
            p_q       <= '0;
            vld_q     <= '0;
            neg_sin_q <= 1'b0;
            neg_cos_q <= 1'b0;
            sin_q     <= '0;
            cos_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            if (i_enable) p_q <= p_d;
            vld_q     <= {vld_q[1:0], i_enable};
            neg_sin_q <= neg_sin;
            neg_cos_q <= neg_cos;
            sin_q     <= sin_d;
            cos_q     <= cos_d;
        end
    end

    assign o_dataSin = sin_q;
    assign o_dataCos = cos_q;
    assign o_valid   = vld_q[2];

endmodule
